// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: op codes, flag bit positions,
// multiplier iteration count and the control state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_ADC  = 4'd1;
  localparam logic [3:0] ALU_OP_SUB  = 4'd2;
  localparam logic [3:0] ALU_OP_SBC  = 4'd3;
  localparam logic [3:0] ALU_OP_AND  = 4'd4;
  localparam logic [3:0] ALU_OP_OR   = 4'd5;
  localparam logic [3:0] ALU_OP_XOR  = 4'd6;
  localparam logic [3:0] ALU_OP_NOT  = 4'd7;
  localparam logic [3:0] ALU_OP_SHL  = 4'd8;
  localparam logic [3:0] ALU_OP_SHR  = 4'd9;
  localparam logic [3:0] ALU_OP_ROL  = 4'd10;
  localparam logic [3:0] ALU_OP_ROR  = 4'd11;
  localparam logic [3:0] ALU_OP_INC  = 4'd12;
  localparam logic [3:0] ALU_OP_DEC  = 4'd13;
  localparam logic [3:0] ALU_OP_MULL = 4'd14;
  localparam logic [3:0] ALU_OP_MULH = 4'd15;

  // Flag register layout is {V,N,Z,C}
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  localparam int MUL_ITER = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul.sv
// Iterative 8x8 unsigned shift-add multiplier. A start while idle captures
// the operands and clears the accumulator; each following edge adds one
// partial product. done is high during the cycle whose edge performs the
// last iteration, and product then shows the final value, so the consumer
// can latch the result on that same edge.
module alu_mul
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [15:0] r_acc;
  logic [2:0]  r_count;
  logic        r_busy;
  logic [15:0] acc_next;

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    acc_next = r_acc + (r_mplier[0] ? r_mcand : 16'h0000);
  end

  assign busy    = r_busy;
  assign done    = r_busy && (r_count == 3'(MUL_ITER - 1));
  assign product = acc_next;

  // Operand capture on start, then MUL_ITER iterations; reset aborts mid-run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else if (start && !r_busy) begin
      r_mcand  <= {8'h00, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= acc_next;
      r_mcand  <= {r_mcand[14:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[7:1]};
      r_count  <= r_count + 3'd1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// 8-bit ALU with latched result and {V,N,Z,C} flag register, result driven
// onto the shared bus under active-low enable.
// Optional feature macro: ALU_MUL_EN enables the iterative multiply ops
// (14 MULL, 15 MULH); without it those op codes leave result and flags alone.
// Handshake: a start is i_ctrlAluNWE low at a rising edge; it is accepted
// only while o_busy is low, and any start seen while o_busy is high is
// dropped with no effect on result, flags or captured operands.
module alu_unit
  import alu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_regA,
  input  logic [7:0] i_bus,
  input  logic [3:0] i_ctrlAluOp,
  input  logic       i_ctrlAluNWE,
  input  logic       i_ctrlAluBusNOE,
  output logic [7:0] o_bus,
  output logic       o_busNOE,
  output logic [3:0] o_flags,
  output logic       o_busy,
  output logic [7:0] o_dbgResult
);

  alu_state_t state, state_next;
  logic [7:0] r_result;
  logic [3:0] r_flags;
  logic       start;
  logic [8:0] sum;
  logic [7:0] res;
  logic       c_new;
  logic       v_new;
  logic       alu_write;

  assign start = !i_ctrlAluNWE && (state == ST_IDLE);

`ifdef ALU_MUL_EN
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [15:0] mul_product;
  logic        r_mul_high;
  logic [7:0]  mul_byte;

  assign mul_start = start && ((i_ctrlAluOp == ALU_OP_MULL) || (i_ctrlAluOp == ALU_OP_MULH));
  assign mul_byte  = r_mul_high ? mul_product[15:8] : mul_product[7:0];

  alu_mul u_mul (
    .clk     (i_clk),
    .reset   (i_reset),
    .start   (mul_start),
    .a       (i_regA),
    .b       (i_bus),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Remember which product byte the running multiply should return
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_mul_high <= 1'b0;
    else if (mul_start) r_mul_high <= (i_ctrlAluOp == ALU_OP_MULH);
  end
`endif

  // Control state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else state <= state_next;
  end

  // Next state: IDLE -> MUL on multiply start, back on the final iteration
  always_comb begin
    state_next = state;
`ifdef ALU_MUL_EN
    case (state)
      ST_IDLE: if (mul_start) state_next = ST_MUL;
      ST_MUL:  if (mul_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
`else
    state_next = ST_IDLE;
`endif
  end

  // Single-cycle datapath: 9-bit arithmetic, carry/borrow and overflow per op
  always_comb begin
    sum       = '0;
    res       = '0;
    c_new     = r_flags[FLAG_C];
    v_new     = 1'b0;
    alu_write = 1'b1;
    case (i_ctrlAluOp)
      ALU_OP_ADD: begin
        sum   = {1'b0, i_regA} + {1'b0, i_bus};
        res   = sum[7:0];
        c_new = sum[8];
        v_new = (i_regA[7] == i_bus[7]) && (res[7] != i_regA[7]);
      end
      ALU_OP_ADC: begin
        sum   = {1'b0, i_regA} + {1'b0, i_bus} + {8'h00, r_flags[FLAG_C]};
        res   = sum[7:0];
        c_new = sum[8];
        v_new = (i_regA[7] == i_bus[7]) && (res[7] != i_regA[7]);
      end
      ALU_OP_SUB: begin
        sum   = {1'b0, i_regA} - {1'b0, i_bus};
        res   = sum[7:0];
        c_new = sum[8];
        v_new = (i_regA[7] != i_bus[7]) && (res[7] != i_regA[7]);
      end
      ALU_OP_SBC: begin
        sum   = {1'b0, i_regA} - {1'b0, i_bus} - {8'h00, r_flags[FLAG_C]};
        res   = sum[7:0];
        c_new = sum[8];
        v_new = (i_regA[7] != i_bus[7]) && (res[7] != i_regA[7]);
      end
      ALU_OP_AND: res = i_regA & i_bus;
      ALU_OP_OR:  res = i_regA | i_bus;
      ALU_OP_XOR: res = i_regA ^ i_bus;
      ALU_OP_NOT: res = ~i_regA;
      ALU_OP_SHL: begin
        res   = {i_regA[6:0], 1'b0};
        c_new = i_regA[7];
      end
      ALU_OP_SHR: begin
        res   = {1'b0, i_regA[7:1]};
        c_new = i_regA[0];
      end
      ALU_OP_ROL: begin
        res   = {i_regA[6:0], r_flags[FLAG_C]};
        c_new = i_regA[7];
      end
      ALU_OP_ROR: begin
        res   = {r_flags[FLAG_C], i_regA[7:1]};
        c_new = i_regA[0];
      end
      ALU_OP_INC: begin
        res   = i_regA + 8'h01;
        v_new = (i_regA == 8'h7F);
      end
      ALU_OP_DEC: begin
        res   = i_regA - 8'h01;
        v_new = (i_regA == 8'h80);
      end
      default: alu_write = 1'b0;
    endcase
  end

  // Result and flag register: single-cycle ops on start, multiply on its last iteration
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (start && alu_write) begin
      r_result <= res;
      r_flags  <= {v_new, res[7], (res == 8'h00), c_new};
`ifdef ALU_MUL_EN
    end else if (mul_done) begin
      r_result <= mul_byte;
      r_flags  <= {1'b0, mul_byte[7], (mul_byte == 8'h00), (mul_product[15:8] != 8'h00)};
`endif
    end
  end

  assign o_busy      = (state == ST_MUL);
  assign o_flags     = r_flags;
  assign o_dbgResult = r_result;
  assign o_busNOE    = i_ctrlAluBusNOE;
  assign o_bus       = i_ctrlAluBusNOE ? 8'h00 : r_result;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed vector table, bus and multiply corner
// sequences, then randomized ops checked against an arithmetic model.
module tb_alu_unit;
  import alu_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_regA;
  logic [7:0] i_bus;
  logic [3:0] i_ctrlAluOp;
  logic       i_ctrlAluNWE;
  logic       i_ctrlAluBusNOE;
  logic [7:0] o_bus;
  logic       o_busNOE;
  logic [3:0] o_flags;
  logic       o_busy;
  logic [7:0] o_dbgResult;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_result;
  logic [3:0]  m_flags;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs[15];

  alu_unit dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_regA          (i_regA),
    .i_bus           (i_bus),
    .i_ctrlAluOp     (i_ctrlAluOp),
    .i_ctrlAluNWE    (i_ctrlAluNWE),
    .i_ctrlAluBusNOE (i_ctrlAluBusNOE),
    .o_bus           (o_bus),
    .o_busNOE        (o_busNOE),
    .o_flags         (o_flags),
    .o_busy          (o_busy),
    .o_dbgResult     (o_dbgResult)
  );

  // clock
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from the op definitions, using plain integer arithmetic.
  // Returns {V,N,Z,C,result}.
  function automatic logic [11:0] ref_alu(input int op, input int a, input int b,
                                          input logic [3:0] f, input logic [7:0] res_now);
    int c, r, cn, vn, sa, sb, sr, r8, p;
    bit arith;
    c = int'(f[0]); cn = c; vn = 0; sr = 0; arith = 0; r = 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0:  begin r = a + b;     cn = (r > 255) ? 1 : 0;       sr = sa + sb;     arith = 1; end
      1:  begin r = a + b + c; cn = (r > 255) ? 1 : 0;       sr = sa + sb + c; arith = 1; end
      2:  begin r = a - b;     cn = (a < b) ? 1 : 0;         sr = sa - sb;     arith = 1; end
      3:  begin r = a - b - c; cn = (a < b + c) ? 1 : 0;     sr = sa - sb - c; arith = 1; end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = 255 - a;
      8:  begin r = a * 2;           cn = (a >= 128) ? 1 : 0; end
      9:  begin r = a / 2;           cn = a % 2; end
      10: begin r = a * 2 + c;       cn = (a >= 128) ? 1 : 0; end
      11: begin r = a / 2 + c * 128; cn = a % 2; end
      12: begin r = a + 1; sr = sa + 1; arith = 1; end
      13: begin r = a - 1; sr = sa - 1; arith = 1; end
      default: begin
`ifdef ALU_MUL_EN
        p  = a * b;
        r  = (op == 14) ? p % 256 : p / 256;
        cn = (p > 255) ? 1 : 0;
`else
        p = 0;
        return {f, res_now};
`endif
      end
    endcase
    if (arith && (sr > 127 || sr < -128)) vn = 1;
    r8 = ((r % 256) + 256) % 256;
    return {vn[0], (r8 >= 128), (r8 == 0), cn[0], r8[7:0]};
  endfunction

  // Present one op for a single start edge; inputs then released
  task automatic drive_start(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge i_clk);
    i_ctrlAluOp  = op;
    i_regA       = a;
    i_bus        = b;
    i_ctrlAluNWE = 1'b0;
    @(negedge i_clk);
    i_ctrlAluNWE = 1'b1;
    i_regA       = ~a;
    i_bus        = ~b;
  endtask

  // Run one op through the scoreboard; waits out a multiply with a cycle bound
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [11:0] e;
    int busy_cycles;
    exp_q.push_back(ref_alu(int'(op), int'(a), int'(b), m_flags, m_result));
    drive_start(op, a, b);
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (!o_busy) break;
      busy_cycles++;
      @(negedge i_clk);
    end
`ifdef ALU_MUL_EN
    if (op >= 4'd14) check($sformatf("mul_busy_len op%0d", op), 16'(busy_cycles), 16'd8);
    else check($sformatf("busy_len op%0d", op), 16'(busy_cycles), 16'd0);
`else
    check($sformatf("busy_len op%0d", op), 16'(busy_cycles), 16'd0);
`endif
    e = exp_q.pop_front();
    check($sformatf("result op%0d a=%h b=%h", op, a, b), 16'(o_dbgResult), 16'(e[7:0]));
    check($sformatf("flags op%0d a=%h b=%h", op, a, b), 16'(o_flags), 16'(e[11:8]));
    check("bus", 16'(o_bus), i_ctrlAluBusNOE ? 16'h0 : 16'(e[7:0]));
    m_result = e[7:0];
    m_flags  = e[11:8];
  endtask

  // Asynchronous reset between edges, checked before the next edge
  task automatic pulse_reset(input string name);
    @(negedge i_clk);
    i_ctrlAluBusNOE = 1'b1;
    #2 i_reset = 1'b1;
    #1;
    check({name, "_result"}, 16'(o_dbgResult), 16'h00);
    check({name, "_flags"}, 16'(o_flags), 16'h0);
    check({name, "_busy"}, 16'(o_busy), 16'h0);
    check({name, "_bus"}, 16'(o_bus), 16'h00);
    check({name, "_busnoe"}, 16'(o_busNOE), 16'h1);
    @(negedge i_clk);
    i_reset  = 1'b0;
    m_result = 8'h00;
    m_flags  = 4'h0;
  endtask

  initial begin
    int busy_cycles;
    vecs[0]  = '{ALU_OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100};
    vecs[1]  = '{ALU_OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011};
    vecs[2]  = '{ALU_OP_SUB, 8'h03, 8'h05, 8'hFE, 4'b0101};
    vecs[3]  = '{ALU_OP_SBC, 8'h10, 8'h01, 8'h0E, 4'b0000};
    vecs[4]  = '{ALU_OP_ROR, 8'h01, 8'h00, 8'h00, 4'b0011};
    vecs[5]  = '{ALU_OP_ROL, 8'h00, 8'h00, 8'h01, 4'b0000};
    vecs[6]  = '{ALU_OP_INC, 8'h7F, 8'h00, 8'h80, 4'b1100};
    vecs[7]  = '{ALU_OP_DEC, 8'h00, 8'h00, 8'hFF, 4'b0100};
    vecs[8]  = '{ALU_OP_SHL, 8'h81, 8'h00, 8'h02, 4'b0001};
    vecs[9]  = '{ALU_OP_AND, 8'hF0, 8'h0F, 8'h00, 4'b0011};
    vecs[10] = '{ALU_OP_NOT, 8'h00, 8'h00, 8'hFF, 4'b0101};
    vecs[11] = '{ALU_OP_SHR, 8'h03, 8'h00, 8'h01, 4'b0001};
    vecs[12] = '{ALU_OP_XOR, 8'hFF, 8'h0F, 8'hF0, 4'b0101};
    vecs[13] = '{ALU_OP_ADC, 8'h01, 8'h01, 8'h03, 4'b0000};
    vecs[14] = '{ALU_OP_OR,  8'h50, 8'h0A, 8'h5A, 4'b0000};

    i_reset = 1'b1;
    i_regA = '0; i_bus = '0; i_ctrlAluOp = '0;
    i_ctrlAluNWE = 1'b1; i_ctrlAluBusNOE = 1'b1;
    m_result = 8'h00; m_flags = 4'h0;
    repeat (2) @(negedge i_clk);
    check("reset_result", 16'(o_dbgResult), 16'h00);
    check("reset_flags", 16'(o_flags), 16'h0);
    check("reset_busy", 16'(o_busy), 16'h0);
    check("reset_bus", 16'(o_bus), 16'h00);
    i_reset = 1'b0;

    // directed vector table, flags carry from one entry to the next
    i_ctrlAluBusNOE = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive_start(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_result", i), 16'(o_dbgResult), 16'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 16'(o_flags), 16'(vecs[i].flags));
      check($sformatf("vec%0d_bus", i), 16'(o_bus), 16'(vecs[i].res));
      check($sformatf("vec%0d_busy", i), 16'(o_busy), 16'h0);
      m_result = vecs[i].res;
      m_flags  = vecs[i].flags;
    end

    // bus enable: result 5A driven when NOE low, zero when high
    check("bus_on", 16'(o_bus), 16'h5A);
    check("busnoe_low", 16'(o_busNOE), 16'h0);
    i_ctrlAluBusNOE = 1'b1;
    #1;
    check("bus_off", 16'(o_bus), 16'h00);
    check("busnoe_high", 16'(o_busNOE), 16'h1);

`ifdef ALU_MUL_EN
    // MULH C8*0A = 07D0; starts during busy and on the final edge are dropped
    i_ctrlAluBusNOE = 1'b0;
    @(negedge i_clk);
    i_ctrlAluOp = ALU_OP_MULH; i_regA = 8'hC8; i_bus = 8'h0A; i_ctrlAluNWE = 1'b0;
    @(negedge i_clk);
    i_ctrlAluNWE = 1'b1; i_regA = 8'h11; i_bus = 8'h22;
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (!o_busy) break;
      busy_cycles++;
      check("mul_stale_bus", 16'(o_bus), 16'h5A);
      i_ctrlAluOp  = ALU_OP_ADD;
      i_ctrlAluNWE = !(k == 2 || k == 7);
      @(negedge i_clk);
    end
    i_ctrlAluNWE = 1'b1;
    check("mulh_busy_len", 16'(busy_cycles), 16'd8);
    check("mulh_result", 16'(o_dbgResult), 16'h07);
    check("mulh_flags", 16'(o_flags), 16'b0001);
    @(negedge i_clk);
    check("mulh_hold", 16'(o_dbgResult), 16'h07);
    m_result = 8'h07; m_flags = 4'b0001;

    // reset during cycle 4 of a multiply: aborted, nothing written later
    pulse_reset("pre_abort");
    drive_start(ALU_OP_MULL, 8'hFF, 8'hFF);
    repeat (3) @(negedge i_clk);
    check("abort_busy_before", 16'(o_busy), 16'h1);
    pulse_reset("abort");
    repeat (10) @(negedge i_clk);
    check("abort_result_after", 16'(o_dbgResult), 16'h00);
    check("abort_flags_after", 16'(o_flags), 16'h0);
    check("abort_busy_after", 16'(o_busy), 16'h0);
`else
    // multiply codes are no-ops in this build
    drive_start(ALU_OP_MULL, 8'h12, 8'h34);
    check("nop_mull_result", 16'(o_dbgResult), 16'h5A);
    check("nop_mull_flags", 16'(o_flags), 16'h0);
    check("nop_mull_busy", 16'(o_busy), 16'h0);
    drive_start(ALU_OP_MULH, 8'hFF, 8'hFF);
    check("nop_mulh_result", 16'(o_dbgResult), 16'h5A);
    check("nop_mulh_busy", 16'(o_busy), 16'h0);
    busy_cycles = 0;
    pulse_reset("midrun");
`endif

    // randomized ops against the model
    for (int i = 0; i < 200; i++) begin
      i_ctrlAluBusNOE = 1'($urandom_range(0, 1));
      run_op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    pulse_reset("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
